// File: rtl/decode_stage_pipe.sv
// RV32I(+optional M) decode stage: one instruction per handshake into a registered control bundle.
// Latency 1 cycle (M-ops N+1); in_ready drops while an M-op counts down or an unaccepted bundle is held.
module decode_stage_pipe #(
  parameter int ENABLE_M   = 0,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_regwrite,
  output logic        out_memread,
  output logic        out_memwrite,
  output logic        out_imm_sel,
  output logic        out_pc_sel,
  output logic [5:0]  out_branch,
  output logic        out_jal,
  output logic        out_jalr,
  output logic [2:0]  out_rw_type,
  output logic [3:0]  out_aluctl,
  output logic        out_md_valid,
  output logic [2:0]  out_md_op,
  output logic        out_illegal,
  output logic        illegal_seen
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Shared ALU encoding is {bit30, func3} of the matching R-type op.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES);

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       imm_sel;
    logic       pc_sel;
    logic [5:0] branch;
    logic       jal;
    logic       jalr;
    logic [2:0] rw_type;
    logic [3:0] aluctl;
    logic       md_valid;
    logic [2:0] md_op;
    logic       illegal;
  } bundle_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HOLD} state_t;

  state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  bundle_t bundle_q, bundle_d, dec;
  logic    illegal_seen_q, illegal_seen_d;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] func3;
  logic       bit30;
  logic [6:0] func7;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  logic is_m_pat, is_m, known, illegal, accept, unused_bits;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign func3  = in_instr[14:12];
  assign bit30  = in_instr[30];
  assign func7  = in_instr[31:25];
  assign unused_bits = ^in_instr[24:15];

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_m_pat  = is_op && (func7 == 7'b0000001);
  assign is_m      = is_m_pat && (ENABLE_M != 0);
  assign known     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_opimm | is_op;
  assign illegal   = !known || (is_branch && func3[2:1] == 2'b01) || (is_m_pat && ENABLE_M == 0);

  always_comb begin
    dec         = '0;
    dec.rw_type = func3;
    dec.imm_sel = is_lui | is_auipc | is_jalr | is_load | is_store | is_opimm;
    dec.pc_sel  = is_auipc;
    dec.aluctl  = ALU_ADD;
    dec.illegal = illegal;
    if ((is_op && !is_m_pat) || is_opimm) begin
      case (func3)
        3'b000:  dec.aluctl = (is_op && bit30) ? ALU_SUB : ALU_ADD;
        3'b001:  dec.aluctl = ALU_SLL;
        3'b010:  dec.aluctl = ALU_SLT;
        3'b011:  dec.aluctl = ALU_SLTU;
        3'b100:  dec.aluctl = ALU_XOR;
        3'b101:  dec.aluctl = bit30 ? ALU_SRA : ALU_SRL;
        3'b110:  dec.aluctl = ALU_OR;
        default: dec.aluctl = ALU_AND;
      endcase
    end else if (is_branch) begin
      dec.aluctl = func3[1] ? ALU_SLTU : (func3[2] ? ALU_SLT : ALU_SUB);
    end
    // Side-effecting enables stay zero for illegal bundles.
    if (!illegal) begin
      dec.regwrite = (rd != 5'd0) && (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op);
      dec.memread  = is_load;
      dec.memwrite = is_store;
      dec.jal      = is_jal;
      dec.jalr     = is_jalr;
      dec.md_valid = is_m;
      dec.md_op    = is_m ? func3 : 3'b000;
      if (is_branch) begin
        case (func3)
          3'b000:  dec.branch = 6'b000001;
          3'b001:  dec.branch = 6'b000010;
          3'b100:  dec.branch = 6'b000100;
          3'b101:  dec.branch = 6'b001000;
          3'b110:  dec.branch = 6'b010000;
          3'b111:  dec.branch = 6'b100000;
          default: dec.branch = 6'b000000;
        endcase
      end
    end
  end

  assign in_ready = !flush && (state_q != ST_BUSY) && ((state_q != ST_HOLD) || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bundle_d       = bundle_q;
    illegal_seen_d = illegal_seen_q | (accept & dec.illegal);
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          // The decrement that reaches zero also publishes the bundle.
          if (cnt_q <= 4'd1) begin
            state_d = ST_HOLD;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_HOLD: if (out_ready) state_d = ST_IDLE;
        default: ;
      endcase
      if (accept) begin
        bundle_d = dec;
        if (dec.md_valid) begin
          state_d = ST_BUSY;
          cnt_d   = func3[2] ? DIV_LD : MUL_LD;
        end else begin
          state_d = ST_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      bundle_q       <= '0;
      illegal_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bundle_q       <= bundle_d;
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign out_valid    = (state_q == ST_HOLD);
  assign out_regwrite = bundle_q.regwrite;
  assign out_memread  = bundle_q.memread;
  assign out_memwrite = bundle_q.memwrite;
  assign out_imm_sel  = bundle_q.imm_sel;
  assign out_pc_sel   = bundle_q.pc_sel;
  assign out_branch   = bundle_q.branch;
  assign out_jal      = bundle_q.jal;
  assign out_jalr     = bundle_q.jalr;
  assign out_rw_type  = bundle_q.rw_type;
  assign out_aluctl   = bundle_q.aluctl;
  assign out_md_valid = bundle_q.md_valid;
  assign out_md_op    = bundle_q.md_op;
  assign out_illegal  = bundle_q.illegal;
  assign illegal_seen = illegal_seen_q;

endmodule
